shifter_right_pipe: RTL and testbench

Five-stage pipelined 32-bit right shifter that executes SRL/SRA/SRLV/SRAV for the execute stage, complementing the left-shift datapath. Each pipeline stage applies one bit of the shift amount: 16, 8, 4, 2, then 1. A valid/ready handshake on both ends lets the CPU stall logic back-pressure the unit without losing or duplicating operations. Throughput is one shift per cycle; latency is five cycles.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shifter_right_stage.sv | 48 ++++
 rtl/shifter_right_pipe.sv | 50 +++++
 tb/tb_shifter_right_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared widths, per-stage record and stage shift-amount helper for the pipelined right shifter.
package shift_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
  } stage_t;

  // Stage k handles the shamt bit worth 2^(SHAMT_W-1-k): 16, 8, 4, 2, 1.
  function automatic int unsigned stage_amt(input int unsigned k);
    return 32'd1 << (SHAMT_W - 1 - k);
  endfunction

endpackage

// File: rtl/shifter_right_stage.sv
// One pipeline stage: conditional right shift by a fixed power of two, plus the stage register
// and its local advance logic.
module shifter_right_stage
  import shift_pkg::*;
#(
  parameter int unsigned STAGE = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t prev,
  input  logic   next_ready,
  output logic   ready,
  output stage_t cur
);

  localparam int unsigned AMT = stage_amt(STAGE);
  localparam int unsigned BIT = SHAMT_W - 1 - STAGE;
  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> AMT);

  stage_t           q;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = prev.data;
    if (prev.shamt[BIT]) begin
      shifted = (prev.data >> AMT) | (prev.fill ? FILL_MASK : '0);
    end
  end

  // Load when empty or when the current contents move on downstream.
  assign ready = !q.valid || next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ready) begin
      q.valid <= prev.valid;
      if (prev.valid) begin
        q.data  <= shifted;
        q.shamt <= prev.shamt;
        q.fill  <= prev.fill;
      end
    end
  end

  assign cur = q;

endmodule

// File: rtl/shifter_right_pipe.sv
// Five-stage pipelined 32-bit right shifter (SRL/SRA) with valid/ready on both ends.
module shifter_right_pipe
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  // st[0] is the input offer; st[k+1] is the register of stage k.
  stage_t st  [SHAMT_W+1];
  logic   rdy [SHAMT_W+1];

  assign st[0] = '{
    valid: in_valid,
    data:  in_data,
    shamt: in_shamt,
    fill:  in_arith & in_data[WIDTH-1]
  };

  assign rdy[SHAMT_W] = out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shifter_right_stage #(
      .STAGE(k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .prev      (st[k]),
      .next_ready(rdy[k+1]),
      .ready     (rdy[k]),
      .cur       (st[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = st[SHAMT_W].valid;
  assign out_data  = st[SHAMT_W].data;

  logic unused_last;
  assign unused_last = ^{st[SHAMT_W].shamt, st[SHAMT_W].fill};

endmodule

// File: tb/tb_shifter_right_pipe.sv
// Directed, table-driven bench for shifter_right_pipe plus stall, back-to-back and reset sequences.
module tb_shifter_right_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  shifter_right_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_arith (in_arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single request into an empty pipe with out_ready high; checks latency and result.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v.data;
    in_shamt = v.shamt;
    in_arith = v.arith;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'd5);
    check($sformatf("vec%0d_data", idx), out_data, v.exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic a);
    logic signed [31:0] sd;
    sd = d;
    return a ? 32'(sd >>> s) : d >> s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_q [$];
    int accepted;
    int n;
    int stale;

    vecs[0]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[1]  = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
    vecs[2]  = '{32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF};
    vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[7]  = '{32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456};
    vecs[8]  = '{32'h8765_4321, 5'd5,  1'b1, 32'hFC3B_2A19};
    vecs[9]  = '{32'h8765_4321, 5'd5,  1'b0, 32'h043B_2A19};
    vecs[10] = '{32'hF000_0000, 5'd28, 1'b1, 32'hFFFF_FFFF};
    vecs[11] = '{32'hFFFF_FFFF, 5'd1,  1'b0, 32'h7FFF_FFFF};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    in_shamt  = 5'd0;
    in_arith  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // Eight back-to-back logical shifts of 0xFFFF0000 by 0..7.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          check($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'd1);
          in_valid = 1'b1;
          in_data  = 32'hFFFF_0000;
          in_shamt = 5'(i);
          in_arith = 1'b0;
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 8; i++) begin
          check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
          check($sformatf("b2b_data%0d", i), out_data, 32'hFFFF_0000 >> i);
          @(negedge clk);
        end
        check("b2b_drained", 32'(out_valid), 32'd0);
      end
    join

    // Fill the pipe with out_ready low, hold for 3 cycles, then drain.
    out_ready = 1'b0;
    accepted  = 0;
    n         = 0;
    @(negedge clk);
    while (accepted < 5 && n < 20) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = 32'h8000_0000 | 32'(accepted * 3);
        in_shamt = 5'(accepted + 1);
        in_arith = accepted[0];
        exp_q.push_back(model(in_data, in_shamt, in_arith));
        accepted++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("fill_accepted", 32'(accepted), 32'd5);
    in_valid = 1'b1;
    in_data  = 32'h5555_5555;
    in_shamt = 5'd3;
    in_arith = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_in_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stall_data%0d", i), out_data, exp_q[0]);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("drain_data%0d", i), out_data, exp_q[i]);
      @(negedge clk);
    end
    check("drain_no_dup", 32'(out_valid), 32'd0);

    // Reset with three requests in flight; a request offered during reset is dropped.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA5A5_0000 + 32'(i);
      in_shamt = 5'd0;
      in_arith = 1'b0;
      @(negedge clk);
    end
    rst      = 1'b1;
    in_data  = 32'h1111_1111;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
